bram_stream_reader: RTL and testbench

Read-side client for the fifobram read interface: accepts a block-read command (start address, word count), issues single-word reads to a BRAM read port (e.g. one read channel of the replicated BRAM block), and delivers the returned words in order on a ready/valid stream. Outstanding reads are credit-limited against an internal output FIFO, so downstream backpressure never loses data regardless of BRAM read latency. It sits between a BRAM region and a compute pipeline that consumes vectors word by word.

---
 rtl/bram_stream_reader.sv | 173 +++++++++++++++++
 tb/tb_bram_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Block-read client for a BRAM read port: turns (addr, count) commands into
// single-word reads and delivers the returned words in order on a ready/valid stream.
module bram_stream_reader #(
  parameter int WIDTH           = 8,
  parameter int LOG2_DEPTH      = 5,
  parameter int LOG2_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LOG2_DEPTH-1:0] cmd_addr,
  input  logic [LOG2_DEPTH:0]   cmd_num_words,
  output logic                  re,
  output logic [LOG2_DEPTH-1:0] raddr,
  output logic [1:0]            rfifobram,
  input  logic                  rvalid,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic                  done
);

  localparam int FIFO_DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam int CW         = LOG2_FIFO_DEPTH + 1;

  localparam logic [LOG2_DEPTH-1:0]      ADDR_ONE  = 1;
  localparam logic [LOG2_DEPTH:0]        WCNT_ONE  = 1;
  localparam logic [LOG2_FIFO_DEPTH-1:0] PTR_ONE   = 1;
  localparam logic [CW-1:0]              CNT_ONE   = 1;
  localparam logic [CW:0]                CREDIT_LIM = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_reg, state_next;
  logic                      re_reg, re_next;
  logic [LOG2_DEPTH-1:0]     raddr_reg, raddr_next;
  logic [LOG2_DEPTH:0]       issue_cnt_reg, issue_cnt_next;
  logic [LOG2_DEPTH:0]       deliver_cnt_reg, deliver_cnt_next;
  logic                      zero_done_reg, zero_done_next;
  logic [CW-1:0]             in_flight_reg, in_flight_next;
  logic [CW-1:0]             fifo_count_reg, fifo_count_next;
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [WIDTH-1:0]          fifo_mem [FIFO_DEPTH];

  logic                      wr_en;
  logic                      rd_en;
  logic [CW:0]               credit_use;
  logic                      credit_ok;

  // A return with nothing outstanding is a leftover from before reset.
  assign wr_en     = rvalid && (in_flight_reg != '0);
  assign out_valid = (fifo_count_reg != '0);
  assign rd_en     = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr_reg] : '0;

  assign re        = re_reg;
  assign raddr     = raddr_reg;
  assign rfifobram = 2'b01;

  // Occupancy as it will stand next cycle; a read may be presented then only
  // if that total still leaves room for its word in the FIFO.
  assign credit_use = {1'b0, in_flight_reg} + {1'b0, fifo_count_reg}
                    + (CW+1)'(re_reg) - (CW+1)'(rd_en);
  assign credit_ok  = (credit_use < CREDIT_LIM);

  always_comb begin
    in_flight_next = in_flight_reg;
    if (re_reg && !wr_en) begin
      in_flight_next = in_flight_reg + CNT_ONE;
    end else if (!re_reg && wr_en) begin
      in_flight_next = in_flight_reg - CNT_ONE;
    end
  end

  always_comb begin
    fifo_count_next = fifo_count_reg;
    if (wr_en && !rd_en) begin
      fifo_count_next = fifo_count_reg + CNT_ONE;
    end else if (!wr_en && rd_en) begin
      fifo_count_next = fifo_count_reg - CNT_ONE;
    end
  end

  always_comb begin
    state_next       = state_reg;
    re_next          = 1'b0;
    raddr_next       = raddr_reg;
    issue_cnt_next   = issue_cnt_reg;
    deliver_cnt_next = rd_en ? (deliver_cnt_reg - WCNT_ONE) : deliver_cnt_reg;
    zero_done_next   = 1'b0;
    cmd_ready        = 1'b0;
    done             = zero_done_reg;

    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          deliver_cnt_next = cmd_num_words;
          if (cmd_num_words == '0) begin
            zero_done_next = 1'b1;
          end else begin
            re_next        = 1'b1;
            raddr_next     = cmd_addr;
            issue_cnt_next = cmd_num_words - WCNT_ONE;
            state_next     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue_cnt_reg == '0) begin
          state_next = DRAIN;
        end else if (credit_ok) begin
          re_next        = 1'b1;
          raddr_next     = raddr_reg + ADDR_ONE;
          issue_cnt_next = issue_cnt_reg - WCNT_ONE;
        end
      end
      DRAIN: begin
        if (deliver_cnt_reg == '0) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      re_reg          <= 1'b0;
      raddr_reg       <= '0;
      issue_cnt_reg   <= '0;
      deliver_cnt_reg <= '0;
      zero_done_reg   <= 1'b0;
      in_flight_reg   <= '0;
      fifo_count_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      re_reg          <= re_next;
      raddr_reg       <= raddr_next;
      issue_cnt_reg   <= issue_cnt_next;
      deliver_cnt_reg <= deliver_cnt_next;
      zero_done_reg   <= zero_done_next;
      in_flight_reg   <= in_flight_next;
      fifo_count_reg  <= fifo_count_next;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // Storage is never cleared; out_valid gates every stale entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= rdata;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed/random bench for bram_stream_reader: a pipelined BRAM model feeds the
// DUT and every delivered word, address and timing is checked against expectations.
module tb_bram_stream_reader;

  localparam int DEPTH = 32;
  localparam int FD    = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_addr = '0;
  logic [5:0] cmd_num_words = '0;
  logic       re;
  logic [4:0] raddr;
  logic [1:0] rfifobram;
  logic       rvalid;
  logic [7:0] rdata;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       done;

  bram_stream_reader #(.WIDTH(8), .LOG2_DEPTH(5), .LOG2_FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_num_words(cmd_num_words),
    .re(re), .raddr(raddr), .rfifobram(rfifobram),
    .rvalid(rvalid), .rdata(rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // BRAM model with selectable latency (1..3 cycles); not tied to DUT reset.
  logic [7:0] mem [DEPTH];
  int         lat = 1;
  logic [2:0] pv = '0;
  logic [7:0] pd [3];
  always @(posedge clk) begin
    pv    <= {pv[1:0], re};
    pd[2] <= pd[1];
    pd[1] <= pd[0];
    pd[0] <= mem[raddr];
  end
  assign rvalid = pv[lat-1];
  assign rdata  = pd[lat-1];

  // Observation: issued reads, delivered words, done pulses, outstanding reads.
  int         cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] got_q [$];
  int         iss_a [$];
  int         iss_c [$];
  int         done_cnt = 0;
  int         done_cyc = -1;
  int         last_xfer_cyc = -1;
  int         first_iss = -1;
  int         outstanding = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (reset) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (rvalid && outstanding > 0) outstanding--;
      if (re) begin
        outstanding++;
        iss_a.push_back(int'(raddr));
        iss_c.push_back(cyc);
        check("in_flight_le_4", 32'(outstanding <= FD), 32'd1);
      end
      if (prev_stall) check("out_data_stable", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        if (got_q.size() == 0) first_iss = iss_a.size();
        got_q.push_back(out_data);
        last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // mode 0: out_ready high; 1: low for 'hold' cycles then high; 2: random.
  task automatic run_cmd(input string tag, input int addr, input int n, input int mode,
                         input int hold, input int budget);
    logic [7:0] exp_d [$];
    int acc;
    int k;
    for (int i = 0; i < n; i++) exp_d.push_back(mem[(addr + i) % DEPTH]);
    got_q.delete();
    iss_a.delete();
    iss_c.delete();
    done_cnt  = 0;
    first_iss = -1;
    check({tag, "_cmd_ready_before"}, 32'(cmd_ready), 32'd1);
    cmd_valid     = 1'b1;
    cmd_addr      = 5'(addr);
    cmd_num_words = 6'(n);
    out_ready     = (mode == 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    acc = cyc;
    check({tag, "_re_first"}, 32'(re), 32'(n != 0));
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k >= hold);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
    check({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, "_done_single"}, 32'(done), 32'd0);
    if (n == 0) begin
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(acc));
      check({tag, "_no_re"}, 32'(iss_a.size()), 32'd0);
    end else begin
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'(last_xfer_cyc + 1));
    end
    check({tag, "_word_count"}, 32'(got_q.size()), 32'(n));
    check({tag, "_read_count"}, 32'(iss_a.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check({tag, "_data"}, 32'(got_q[i]), 32'(exp_d[i]));
    for (int i = 0; i < n && i < iss_a.size(); i++)
      check({tag, "_raddr"}, 32'(iss_a[i]), 32'((addr + i) % DEPTH));
    if (mode == 0 && lat == 1) begin
      for (int i = 0; i < n && i < iss_c.size(); i++)
        check({tag, "_re_cycle"}, 32'(iss_c[i]), 32'(acc + i));
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_no_extra_done"}, 32'(done_cnt), 32'd1);
    $display("%s: addr=%0d n=%0d words=%0d reads=%0d done=%0d", tag, addr, n,
             got_q.size(), iss_a.size(), done_cnt);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 100);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_re", 32'(re), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    check("rst_rfifobram", 32'(rfifobram), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    lat = 1;
    run_cmd("basic", 3, 4, 0, 0, 50);
    run_cmd("wrap", 30, 4, 0, 0, 50);
    run_cmd("backpressure", 5, 8, 1, 10, 100);
    check("bp_reads_before_xfer", 32'(first_iss >= 1 && first_iss <= FD), 32'd1);
    run_cmd("zero", 7, 0, 0, 0, 20);

    lat = 3;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
    run_cmd("lat3_rand", int'($urandom_range(0, DEPTH - 1)), 32, 2, 0, 2000);

    // Reset in the middle of a command, after two words have been delivered.
    got_q.delete();
    iss_a.delete();
    iss_c.delete();
    done_cnt      = 0;
    cmd_valid     = 1'b1;
    cmd_addr      = 5'd10;
    cmd_num_words = 6'd16;
    out_ready     = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 100 && got_q.size() < 2; k++) begin
      @(posedge clk);
      #1;
    end
    check("mid_two_delivered", 32'(got_q.size()), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_re", 32'(re), 32'd0);
    check("mid_rst_raddr", 32'(raddr), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("post_rst_stray_ignored", 32'(out_valid), 32'd0);
    end
    check("post_rst_no_done", 32'(done_cnt), 32'd0);
    $display("reset_mid: delivered_before_reset=2 done=%0d", done_cnt);
    run_cmd("after_reset", 20, 6, 0, 0, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
